// File: rtl/stream_demux_pkg.sv
// Shared types and defaults for the stream demultiplexer.
// Imported by the interface, the slot and the top level.
package stream_demux_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_N_OUT = 4;

    typedef logic [7:0] drop_cnt_t;

    localparam drop_cnt_t DROP_MAX = 8'hFF;

endpackage

// File: rtl/stream_demux_if.sv
// Upstream valid/ready/select stream plus the flattened downstream lanes.
// master = producer/consumer environment, slave = the demux itself.
interface stream_demux_if
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N_OUT = DEFAULT_N_OUT
);
    localparam int SEL_W = $clog2(N_OUT);

    logic                   up_valid;
    logic [SEL_W-1:0]       up_sel;
    logic [WIDTH-1:0]       up_data;
    logic                   up_ready;
    logic [N_OUT-1:0]       down_valid;
    logic [N_OUT*WIDTH-1:0] down_data;
    logic [N_OUT-1:0]       down_ready;

    modport master (
        output up_valid, up_sel, up_data, down_ready,
        input  up_ready, down_valid, down_data
    );

    modport slave (
        input  up_valid, up_sel, up_data, down_ready,
        output up_ready, down_valid, down_data
    );

endinterface

// File: rtl/stream_demux_slot.sv
// One-entry register slot backing a single downstream lane.
// A write wins over a drain, so the slot can refill in the cycle it empties.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Data is only loaded on a write; after a drain the stale value is simply held.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (wr_en) begin
            valid <= 1'b1;
            data  <= wr_data;
        end else if (valid && rd_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Routes one upstream stream to N_OUT independently stalling lanes by up_sel.
// Out-of-range selects are swallowed and counted in a saturating drop counter.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N_OUT = DEFAULT_N_OUT
) (
    input  logic      clk,
    input  logic      rst,
    stream_demux_if.slave bus,
    output drop_cnt_t drop_count
);

    localparam int SEL_W    = $clog2(N_OUT);
    localparam int SEL_SPAN = 1 << SEL_W;
    localparam logic [SEL_W:0] LANE_LIMIT = (SEL_W+1)'(N_OUT);

    logic [N_OUT-1:0]    full;
    logic [N_OUT-1:0]    wr_en;
    logic [SEL_SPAN-1:0] full_ext;
    logic [SEL_SPAN-1:0] ready_ext;
    logic [WIDTH-1:0]    slot_data [N_OUT];
    logic                sel_legal;
    logic                up_ready_int;
    logic                accept;

    // Pad lane state to the full select range so an illegal index never reads past the vector.
    always_comb begin
        full_ext                 = '0;
        ready_ext                = '0;
        full_ext[N_OUT-1:0]      = full;
        ready_ext[N_OUT-1:0]     = bus.down_ready;
    end

    assign sel_legal = {1'b0, bus.up_sel} < LANE_LIMIT;

    always_comb begin
        up_ready_int = 1'b0;
        if (!rst) begin
            if (!sel_legal) begin
                up_ready_int = 1'b1;
            end else begin
                up_ready_int = !full_ext[bus.up_sel] || ready_ext[bus.up_sel];
            end
        end
    end

    assign bus.up_ready   = up_ready_int;
    assign accept         = bus.up_valid && up_ready_int;
    assign bus.down_valid = full;

    for (genvar i = 0; i < N_OUT; i++) begin : g_lane
        assign wr_en[i] = accept && sel_legal && (bus.up_sel == SEL_W'(i));

        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en[i]),
            .wr_data  (bus.up_data),
            .rd_ready (bus.down_ready[i]),
            .valid    (full[i]),
            .data     (slot_data[i])
        );

        assign bus.down_data[i*WIDTH +: WIDTH] = slot_data[i];
    end

    // Dropped transfers are still handshaken upstream; the counter sticks at its maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (accept && !sel_legal && (drop_count != DROP_MAX)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed vector table on a 4-lane instance, drop saturation
// on a 3-lane instance, then random traffic on both against a per-lane slot model.
module tb_stream_demux;
    import stream_demux_pkg::*;

    logic clk = 1'b1;
    logic rst;

    always #5 clk = ~clk;

    stream_demux_if #(.WIDTH(8), .N_OUT(4)) bus4 ();
    stream_demux_if #(.WIDTH(8), .N_OUT(3)) bus3 ();

    drop_cnt_t drop4;
    drop_cnt_t drop3;

    stream_demux #(.WIDTH(8), .N_OUT(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus4.slave),
        .drop_count (drop4)
    );

    stream_demux #(.WIDTH(8), .N_OUT(3)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus3.slave),
        .drop_count (drop3)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [1:0]  sel;
        logic [7:0]  dat;
        logic [3:0]  drdy;
        logic        chk;
        logic        exp_rdy;
        logic [3:0]  exp_dv;
        logic [31:0] exp_dd;
        logic [31:0] dd_mask;
    } vec_t;

    vec_t vecs[$];

    int total = 0;
    int bad   = 0;

    logic       in_v [2];
    logic [1:0] in_s [2];
    logic [7:0] in_d [2];
    logic [3:0] in_r [2];

    logic        act_rdy  [2];
    logic [3:0]  act_dv   [2];
    logic [31:0] act_dd   [2];
    logic [7:0]  act_drop [2];

    bit       m_has [2][4];
    bit [7:0] m_val [2][4];
    int       m_drop [2];

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] s,
                                input logic [7:0] d, input logic [3:0] dr, input logic c,
                                input logic er, input logic [3:0] edv,
                                input logic [31:0] edd, input logic [31:0] msk);
        vec_t t;
        t.rst = r; t.vld = v; t.sel = s; t.dat = d; t.drdy = dr; t.chk = c;
        t.exp_rdy = er; t.exp_dv = edv; t.exp_dd = edd; t.dd_mask = msk;
        return t;
    endfunction

    task automatic applyStimulus(input logic r);
        rst             = r;
        bus4.up_valid   = in_v[0];
        bus4.up_sel     = in_s[0];
        bus4.up_data    = in_d[0];
        bus4.down_ready = in_r[0];
        bus3.up_valid   = in_v[1];
        bus3.up_sel     = in_s[1];
        bus3.up_data    = in_d[1];
        bus3.down_ready = in_r[1][2:0];
    endtask

    task automatic sampleOutputs();
        act_rdy[0]  = bus4.up_ready;
        act_dv[0]   = bus4.down_valid;
        act_dd[0]   = bus4.down_data;
        act_drop[0] = drop4;
        act_rdy[1]  = bus3.up_ready;
        act_dv[1]   = {1'b0, bus3.down_valid};
        act_dd[1]   = {8'h00, bus3.down_data};
        act_drop[1] = drop3;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setIdle3();
        in_v[1] = 1'b0; in_s[1] = 2'd0; in_d[1] = 8'h00; in_r[1] = 4'hF;
    endtask

    // Expected behaviour stated directly from the handshake rules: each lane is a one-deep buffer.
    task automatic modelCheckAndStep(input logic r, input int cyc);
        int   n;
        logic exp_rdy;
        logic [3:0] exp_dv;
        for (int d = 0; d < 2; d++) begin
            n = (d == 0) ? 4 : 3;
            if (r) exp_rdy = 1'b0;
            else if (int'(in_s[d]) >= n) exp_rdy = 1'b1;
            else exp_rdy = !m_has[d][in_s[d]] || in_r[d][in_s[d]];
            exp_dv = '0;
            for (int l = 0; l < n; l++) exp_dv[l] = m_has[d][l];
            checkOutput($sformatf("rnd%0d.dut%0d.up_ready", cyc, n), 32'(act_rdy[d]), 32'(exp_rdy));
            checkOutput($sformatf("rnd%0d.dut%0d.down_valid", cyc, n), 32'(act_dv[d]), 32'(exp_dv));
            for (int l = 0; l < n; l++) begin
                if (m_has[d][l])
                    checkOutput($sformatf("rnd%0d.dut%0d.lane%0d", cyc, n, l),
                                32'(act_dd[d][l*8 +: 8]), 32'(m_val[d][l]));
            end
            checkOutput($sformatf("rnd%0d.dut%0d.drop_count", cyc, n), 32'(act_drop[d]), 32'(m_drop[d]));
            if (r) begin
                for (int l = 0; l < 4; l++) m_has[d][l] = 1'b0;
                m_drop[d] = 0;
            end else begin
                for (int l = 0; l < n; l++)
                    if (m_has[d][l] && in_r[d][l]) m_has[d][l] = 1'b0;
                if (in_v[d] && exp_rdy) begin
                    if (int'(in_s[d]) < n) begin
                        m_has[d][in_s[d]] = 1'b1;
                        m_val[d][in_s[d]] = in_d[d];
                    end else if (m_drop[d] < 255) begin
                        m_drop[d]++;
                    end
                end
            end
        end
    endtask

    initial begin
        vecs.push_back(mk(1,1,0,8'h99,4'hF, 0,0,4'h0,32'h0,        32'h0));
        vecs.push_back(mk(1,1,0,8'h99,4'hF, 1,0,4'h0,32'h0,        32'hFFFFFFFF));
        vecs.push_back(mk(0,1,0,8'h11,4'hF, 1,1,4'h0,32'h0,        32'h0));
        vecs.push_back(mk(0,1,1,8'h22,4'hF, 1,1,4'h1,32'h11,       32'hFF));
        vecs.push_back(mk(0,1,2,8'h33,4'hF, 1,1,4'h2,32'h2200,     32'hFF00));
        vecs.push_back(mk(0,1,3,8'h44,4'hF, 1,1,4'h4,32'h330000,   32'hFF0000));
        vecs.push_back(mk(0,0,0,8'h00,4'hF, 1,1,4'h8,32'h44000000, 32'hFF000000));
        vecs.push_back(mk(0,0,0,8'h00,4'hF, 1,1,4'h0,32'h0,        32'h0));
        vecs.push_back(mk(0,1,2,8'hA5,4'hB, 1,1,4'h0,32'h0,        32'h0));
        vecs.push_back(mk(0,1,2,8'h5A,4'hB, 1,0,4'h4,32'hA50000,   32'hFF0000));
        vecs.push_back(mk(0,1,2,8'h5A,4'hB, 1,0,4'h4,32'hA50000,   32'hFF0000));
        vecs.push_back(mk(0,1,2,8'h5A,4'hF, 1,1,4'h4,32'hA50000,   32'hFF0000));
        vecs.push_back(mk(0,0,2,8'h00,4'hF, 1,1,4'h4,32'h5A0000,   32'hFF0000));
        vecs.push_back(mk(0,0,0,8'h00,4'hF, 1,1,4'h0,32'h0,        32'h0));
        vecs.push_back(mk(0,1,1,8'h66,4'hD, 1,1,4'h0,32'h0,        32'h0));
        vecs.push_back(mk(0,1,3,8'h77,4'hD, 1,1,4'h2,32'h6600,     32'hFF00));
        vecs.push_back(mk(0,1,1,8'h88,4'hD, 1,0,4'hA,32'h77006600, 32'hFF00FF00));
        vecs.push_back(mk(0,0,1,8'h00,4'hD, 1,0,4'h2,32'h6600,     32'hFF00));
        vecs.push_back(mk(0,1,1,8'h99,4'hF, 1,1,4'h2,32'h6600,     32'hFF00));
        vecs.push_back(mk(0,1,1,8'hAB,4'hF, 1,1,4'h2,32'h9900,     32'hFF00));
        vecs.push_back(mk(0,0,0,8'h00,4'hF, 1,1,4'h2,32'hAB00,     32'hFF00));
        vecs.push_back(mk(0,1,0,8'hC0,4'h0, 1,1,4'h0,32'h0,        32'h0));
        vecs.push_back(mk(0,1,2,8'hC2,4'h0, 1,1,4'h1,32'hC0,       32'hFF));
        vecs.push_back(mk(1,0,0,8'h00,4'h0, 1,0,4'h5,32'hC200C0,   32'hFF00FF));
        vecs.push_back(mk(0,1,3,8'hD3,4'h0, 1,1,4'h0,32'h0,        32'hFFFFFFFF));
        vecs.push_back(mk(0,0,0,8'h00,4'hF, 1,1,4'h8,32'hD3000000, 32'hFF000000));
        vecs.push_back(mk(0,0,0,8'h00,4'hF, 1,1,4'h0,32'h0,        32'h0));

        // Directed table on the 4-lane instance; the 3-lane one idles alongside.
        foreach (vecs[k]) begin
            in_v[0] = vecs[k].vld; in_s[0] = vecs[k].sel;
            in_d[0] = vecs[k].dat; in_r[0] = vecs[k].drdy;
            setIdle3();
            applyStimulus(vecs[k].rst);
            @(negedge clk);
            sampleOutputs();
            checkOutput($sformatf("row%0d.up_ready", k), 32'(act_rdy[0]), 32'(vecs[k].exp_rdy));
            if (vecs[k].chk) begin
                checkOutput($sformatf("row%0d.down_valid", k), 32'(act_dv[0]), 32'(vecs[k].exp_dv));
                if (vecs[k].dd_mask != 32'h0)
                    checkOutput($sformatf("row%0d.down_data", k),
                                act_dd[0] & vecs[k].dd_mask, vecs[k].exp_dd & vecs[k].dd_mask);
                checkOutput($sformatf("row%0d.drop_count", k), 32'(act_drop[0]), 32'h0);
            end
            @(posedge clk);
            #1;
        end

        // Out-of-range select on the 3-lane instance: always ready, never routed, count saturates.
        in_v[0] = 1'b0; in_s[0] = 2'd0; in_d[0] = 8'h00; in_r[0] = 4'hF;
        for (int j = 0; j < 300; j++) begin
            in_v[1] = 1'b1; in_s[1] = 2'd3; in_d[1] = 8'($urandom); in_r[1] = 4'($urandom);
            applyStimulus(1'b0);
            @(negedge clk);
            sampleOutputs();
            checkOutput($sformatf("drop%0d.up_ready", j), 32'(act_rdy[1]), 32'h1);
            checkOutput($sformatf("drop%0d.down_valid", j), 32'(act_dv[1]), 32'h0);
            checkOutput($sformatf("drop%0d.drop_count", j), 32'(act_drop[1]), 32'((j < 255) ? j : 255));
            @(posedge clk);
            #1;
        end

        // Random traffic with occasional resets on both instances.
        in_v[0] = 1'b0; setIdle3();
        applyStimulus(1'b1);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int l = 0; l < 4; l++) begin
                m_has[d][l] = 1'b0;
                m_val[d][l] = 8'h00;
            end
            m_drop[d] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            logic r;
            r = ($urandom_range(0, 39) == 0);
            for (int d = 0; d < 2; d++) begin
                in_v[d] = ($urandom_range(0, 3) != 0);
                in_s[d] = 2'($urandom_range(0, 3));
                in_d[d] = 8'($urandom);
                in_r[d] = 4'($urandom);
            end
            applyStimulus(r);
            @(negedge clk);
            sampleOutputs();
            modelCheckAndStep(r, c);
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
# stream_demux

Single-input, multi-output stream demultiplexer: one upstream valid/ready stream with a per-transfer destination select is routed to one of `N_OUT` downstream valid/ready lanes, each backed by a one-entry register slot. It is the inverse of our select-driven mux primitives: it splits one source into selected sinks instead of merging sources. It sits between a single producer and several independent consumers that may stall individually.

## Interface
- `WIDTH`, 8: data width per transfer.
- `N_OUT`, 4: number of downstream lanes, 2..16.
- `SEL_W`, `$clog2(N_OUT)`: width of the destination select. Derived; not overridden.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `up_valid`  in  1  upstream transfer offered.
- `up_sel`  in  SEL_W  destination lane index for the offered transfer.
- `up_data`  in  WIDTH  upstream payload.
- `up_ready`  out  1  upstream transfer accepted this cycle when high with `up_valid`.
- `down_valid`  out  N_OUT  per-lane slot occupied.
- `down_data`  out  N_OUT*WIDTH  per-lane payload, flattened. Lane i is in bits [i*WIDTH +: WIDTH].
- `down_ready`  in  N_OUT  per-lane consumer ready.
- `drop_count`  out  8  saturating count of transfers dropped because `up_sel` was out of range.

## Operation
- Each lane i has a slot with a `full[i]` flag and a `data[i]` register. `down_valid[i] = full[i]` and `down_data` lane i = `data[i]`.
- A transfer is accepted when `up_valid && up_ready`.
- For a legal select (`up_sel < N_OUT`): `up_ready = !full[up_sel] || down_ready[up_sel]`. The slot may refill in the same cycle it drains.
- For an illegal select (`up_sel >= N_OUT`, only possible when N_OUT is not a power of 2): `up_ready = 1`, the payload is discarded, and `drop_count` increments. At 255 the counter saturates and holds.
- Per lane, each cycle (priority top-down):
  - accept to lane i → `full[i] <= 1`, `data[i] <= up_data`.
  - else if `full[i] && down_ready[i]` → `full[i] <= 0`; `data[i]` is held, its value is don't-care.
  - else hold.
- Lanes other than `up_sel` drain independently in the same cycle. A stalled lane never blocks transfers to other lanes.
- While `down_valid[i] && !down_ready[i]`, `down_data` lane i is held stable.
- `up_ready` is combinational from `up_sel`, `full`, and `down_ready`. Upstream must not make `up_valid` depend on `up_ready`.
- At most one upstream transfer is accepted per cycle.

## Timing
- Reset, registered in the cycle `rst` is high: `full` = 0 for all lanes, all `down_data` = 0, `drop_count` = 0. During reset `up_ready` = 0.
- `rst` asserted mid-operation discards all slot contents. No downstream handshake completes in that cycle.
- Latency: data accepted in cycle t appears on `down_valid`/`down_data` in cycle t+1.
- Throughput to one lane with `down_ready` held high: 1 transfer per cycle, sustained.
- Simultaneous drain and refill of the same lane: the new data is visible next cycle and `down_valid` stays high with no bubble.

## Structure
- Package `stream_demux_pkg` holds:
  - default `WIDTH` and `N_OUT` localparams;
  - `typedef logic [7:0] drop_cnt_t`;
  - a `DROP_MAX = 8'hFF` constant.
- Sub-module `demux_slot`: the one-entry register (`clk`, `rst`, `wr_en`, `wr_data`, `rd_ready`, `valid`, `data`). Instantiate it N_OUT times in a generate loop.
- The top level holds the select decode, the `up_ready` logic, and the drop counter.

## Test plan
- Reset: drive `rst` for 2 cycles with `up_valid=1` → `up_ready=0`, `down_valid=0000`, `drop_count=0`.
- Routing: with all `down_ready=1`, send 0x11 sel 0, 0x22 sel 1, 0x33 sel 2, 0x44 sel 3 on consecutive cycles → each value appears on its own lane exactly one cycle later, each valid for one cycle.
- Backpressure: hold `down_ready[2]=0`, send 0xA5 then 0x5A to sel 2 → first accepted; `up_ready=0` for the second and lane 2 holds 0xA5. Release `down_ready[2]` → 0x5A is accepted in that same cycle and appears next cycle.
- Independence: lane 1 full and stalled, then send 0x77 to sel 3 → accepted at once and `down_valid[3]=1` next cycle.
- Illegal select: with `N_OUT=3`, send 300 transfers with `up_sel=3` → `up_ready=1` every cycle, no `down_valid` rises, `drop_count` ends at 255.
- Reset mid-stream: lanes 0 and 2 full, pulse `rst` for one cycle → next cycle `down_valid=000` and `down_data` all zero, and a subsequent transfer routes normally.
